intr_ctrl: RTL

- Next-generation interrupt controller for the flex_qspi peripheral set.
- Per-channel trigger mode is set at run time from a register interface, not by a parameter. Adds per-channel enable, an optional input synchroniser, fixed-priority arbitration and a single CPU request with an ID/acknowledge handshake.
- Sits between peripheral event sources (QSPI done, FIFO levels, GPIO) and the core's interrupt input.

---
 rtl/intr_ctrl_if.sv | 27 ++
 rtl/intr_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/intr_ctrl_if.sv
// rtl/intr_ctrl_if.sv - event source, software control and CPU request bundle for intr_ctrl
interface intr_ctrl_if #(
    parameter int INTR_NUM = 8,
    parameter int ID_W     = 3
);
    logic [INTR_NUM-1:0]   intr_src;
    logic [2*INTR_NUM-1:0] intr_mode;
    logic [INTR_NUM-1:0]   intr_en;
    logic                  intr_clr;
    logic [INTR_NUM-1:0]   intr_clr_sel;
    logic [INTR_NUM-1:0]   intr_sig;
    logic                  irq;
    logic [ID_W-1:0]       irq_id;
    logic                  irq_ack;

    // Sources, software and core side
    modport master (
        output intr_src, intr_mode, intr_en, intr_clr, intr_clr_sel, irq_ack,
        input  intr_sig, irq, irq_id
    );

    // Interrupt controller side
    modport slave (
        input  intr_src, intr_mode, intr_en, intr_clr, intr_clr_sel, irq_ack,
        output intr_sig, irq, irq_id
    );
endinterface

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - multi-channel interrupt controller with run-time trigger modes and id/ack handshake
module intr_ctrl #(
    parameter int INTR_NUM    = 8,
    parameter int ID_W        = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    intr_ctrl_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    logic [INTR_NUM-1:0] s;
    logic [INTR_NUM-1:0] prev_q;
    logic [INTR_NUM-1:0] sig_q, sig_d;
    logic [INTR_NUM-1:0] ev, set_v, clr_v, req, id_hot;
    logic                cur_req;
    logic [ID_W-1:0]     next_id;
    logic                irq_q;
    logic [ID_W-1:0]     irq_id_q;
    state_t              state_q;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = bus.intr_src;
        end else begin : g_sync
            logic [INTR_NUM-1:0] sync_q [SYNC_STAGES];

            // Shift raw sources through the synchroniser chain
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
                end else begin
                    sync_q[0] <= bus.intr_src;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Previous value tracks every channel so mode changes never fake an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= '0;
        else     prev_q <= s;
    end

    // Event detection, pending set/clear and arbitration inputs
    always_comb begin
        ev      = '0;
        clr_v   = '0;
        id_hot  = '0;
        next_id = '0;
        for (int j = 0; j < INTR_NUM; j++) begin
            case (bus.intr_mode[2*j +: 2])
                2'b00:   ev[j] = ~prev_q[j] & s[j];
                2'b01:   ev[j] = prev_q[j] & ~s[j];
                2'b10:   ev[j] = s[j];
                default: ev[j] = ~s[j];
            endcase
            id_hot[j] = (irq_id_q == ID_W'(j));
            clr_v[j]  = (bus.intr_clr & bus.intr_clr_sel[j]) |
                        ((state_q == BUSY) & bus.irq_ack & id_hot[j]);
        end
        set_v   = ev & bus.intr_en;
        sig_d   = (sig_q & ~clr_v) | set_v;
        req     = sig_q & bus.intr_en;
        cur_req = |(req & id_hot);
        // Descending scan so the lowest requesting index is the one left standing
        for (int j = INTR_NUM - 1; j >= 0; j--) begin
            if (req[j]) next_id = ID_W'(j);
        end
    end

    // Pending flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= '0;
        else     sig_q <= sig_d;
    end

    // Presentation FSM: pick in IDLE, hold id in BUSY until ack or withdrawal
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            irq_q    <= 1'b0;
            irq_id_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        irq_id_q <= next_id;
                        irq_q    <= 1'b1;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.irq_ack || !cur_req) begin
                        irq_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    irq_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.intr_sig = sig_q;
    assign bus.irq      = irq_q;
    assign bus.irq_id   = irq_id_q;
endmodule
